// File: rtl/sig_verify_arbiter.sv
// Round-robin arbiter sharing one signature verifier among NUM_REQ requesters.
// Optional failure counter enabled with macro SIG_VERIFY_ARBITER_FAILCNT_EN.
module sig_verify_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned VERIFY_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*256-1:0] req_signature,
  input  logic [NUM_REQ*256-1:0] req_hash,
  output logic [255:0]           ver_signature,
  output logic [255:0]           ver_hash,
  output logic                   ver_enable,
  input  logic                   ver_match,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic                   rsp_match,
  output logic                   busy
`ifdef SIG_VERIFY_ARBITER_FAILCNT_EN
  ,
  output logic [15:0]            fail_count
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (VERIFY_LATENCY > 1) ? $clog2(VERIFY_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  grant_id;
  logic           grant_any;
  logic           accept;
  logic           wait_last;
  logic [CW-1:0]  wait_cnt;
  logic [255:0]   sig_q, hash_q;
  logic [PW-1:0]  id_q;
  logic           match_q;
  logic [2:0]     rsp_id_q;
  int unsigned    idx;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[PW'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = PW'(idx);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_any && !reset;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign wait_last = (wait_cnt == CW'(VERIFY_LATENCY - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      sig_q    <= '0;
      hash_q   <= '0;
      id_q     <= '0;
      match_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        sig_q  <= req_signature[256*grant_id +: 256];
        hash_q <= req_hash[256*grant_id +: 256];
        id_q   <= grant_id;
        rr_ptr <= (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !wait_last) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // rsp_id updates together with rsp_match so both hold between pulses.
      if (state == WAIT && wait_last) begin
        match_q  <= ver_match;
        rsp_id_q <= 3'(id_q);
      end
    end
  end

  // Outputs are forced low while reset is high, including the first reset cycle.
  assign ver_enable    = (state == ISSUE) && !reset;
  assign rsp_valid     = (state == RESP) && !reset;
  assign busy          = (state != IDLE) && !reset;
  assign ver_signature = reset ? '0 : sig_q;
  assign ver_hash      = reset ? '0 : hash_q;
  assign rsp_match     = match_q && !reset;
  assign rsp_id        = reset ? '0 : rsp_id_q;

`ifdef SIG_VERIFY_ARBITER_FAILCNT_EN
  logic [15:0] fail_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_q <= '0;
    end else if (state == RESP && !match_q && fail_q != '1) begin
      fail_q <= fail_q + 16'd1;
    end
  end

  assign fail_count = reset ? '0 : fail_q;
`endif

endmodule
